rs_alu: RTL
===========

// Module: rs_alu
// PURPOSE
//  ALU reservation station. Buffers decoded ALU/branch/jump ops from dispatch until both
//  source operands are valid, snooping the two result broadcast buses (ALU, LSB). Each
//  cycle it issues at most one ready op to the combinational execute unit through
//  registered outputs. Sits between dispatch/ROB allocation and ex.
// PARAMETERS
//  DEPTH   16  number of entries (power of 2, >=2)
//  IDX_W    4  log2(DEPTH)
//  OP_W     6  op-type width (`opTypeWidth); op value 0 = NOP
//  DATA_W  32  operand/result width (`dataWidth); also imm and pc width
//  TAG_W    4  ROB tag width (`tagWidth)
// PORTS
//  clk_in         in   1       clock
//  rst_in         in   1       async reset, active-high
//  rdy_in         in   1       global ready; 0 = stall
//  clear_in       in   1       mispredict flush (synchronous)
//  disp_valid     in   1       dispatch request
//  disp_op        in   OP_W    op type
//  disp_vj/_vk    in   DATA_W  rs1/rs2 value (meaningful when matching rdy bit = 1)
//  disp_rdyj/_rdyk in  1       operand already valid
//  disp_qj/_qk    in   TAG_W   producer ROB tag when rdy bit = 0
//  disp_imm       in   DATA_W  sign-extended immediate
//  disp_pc        in   DATA_W  instruction pc
//  disp_tag       in   TAG_W   destination ROB tag
//  full_out       out  1       no free entry (combinational)
//  alu_cdb_valid  in   1       ALU broadcast valid
//  alu_cdb_tag    in   TAG_W   ALU broadcast tag
//  alu_cdb_data   in   DATA_W  ALU broadcast data
//  lsb_cdb_valid/_tag/_data    same triple for load/store buffer
//  op_type_ex     out  OP_W    issued op; NOP when nothing issued
//  data_rs1_ex    out  DATA_W  issued rs1 value
//  data_rs2_ex    out  DATA_W  issued rs2 value
//  imm_ex         out  DATA_W  issued immediate
//  pc_ex          out  DATA_W  issued pc
//  tag_in_rob     out  TAG_W   issued destination tag
// BEHAVIOUR
//  - Reset (async, rst_in=1): all entries invalid; every output reg 0 (op_type_ex = NOP).
//  - Entry: busy, op, vj, vk, rdyj, rdyk, qj, qk, imm, pc, tag.
//  - full_out = (busy count == DEPTH); independent of same-cycle issue.
//  - Priority each edge: rst_in > clear_in > !rdy_in > normal.
//  - clear_in=1: all busy cleared, op_type_ex <= NOP; dispatch ignored that cycle.
//  - rdy_in=0: no dispatch, no issue, op_type_ex <= NOP; entries hold, but wakeup still
//    applies (a broadcast during stall is never lost).
//  - Dispatch (disp_valid & !full_out): write lowest-index free entry. Operand bypass: if
//    rdy=0 and a valid CDB tag equals q this cycle, store the CDB data with rdy=1 (ALU bus
//    wins if both buses match, which is illegal anyway). disp_valid while full: dropped,
//    no state change.
//  - Wakeup: every busy entry with rdyX=0 and qX == valid CDB tag latches data, rdyX<=1.
//  - Issue: among entries with busy & rdyj & rdyk as registered at cycle start, pick
//    lowest index; drive its fields to the *_ex regs at the edge and clear busy.
//    None ready -> op_type_ex <= NOP, other outputs don't care (hold).
//  - Latencies: dispatch->earliest issue = 1 edge (entry written at edge N, out regs at
//    edge N+1). Wakeup at edge N -> issue at edge N+1. Same-cycle dispatch/wakeup/issue
//    to different entries all take effect together.
//  - Issued entry is freed at the same edge; its slot is reusable next cycle.
//  - Tags compared on full TAG_W; no width conversion on data (pass-through).
// TESTING
//  1 Reset: rst_in=1 mid-traffic -> op_type_ex=0, full_out=0 immediately; 2 cycles later
//    still NOP.
//  2 Ready dispatch: ADD vj=5 vk=7 tag=3, both rdy -> next edge op_type_ex=ADD,
//    data_rs1_ex=5, data_rs2_ex=7, tag_in_rob=3; following cycle NOP.
//  3 Wakeup: dispatch ADDI rdyj=0 qj=6 imm=1; 3 cycles later lsb_cdb tag6 data=0x10 ->
//    issue one edge later with data_rs1_ex=0x10, imm_ex=1.
//  4 Bypass: dispatch qk=2 rdyk=0 in the same cycle alu_cdb tag2 data=0xABCD ->
//    issues next edge with data_rs2_ex=0xABCD.
//  5 Full/order: 16 dispatches with unresolved deps -> full_out=1, 17th dropped;
//    broadcast resolving entries 4 and 9 -> entry 4 issues first, entry 9 next cycle,
//    full_out=0 after first issue.
//  6 Flush/stall: 3 ready entries, rdy_in=0 two cycles -> no issue, CDB capture kept;
//    then clear_in=1 -> all entries gone, op_type_ex=NOP, full_out=0.

Source files
------------

// File: rtl/rs_alu.sv
// -----------------------------------------------------------------------------
// rs_alu -- ALU reservation station
//
// Holds decoded ALU/branch/jump ops from dispatch until both source operands are
// valid. Operands are captured from the ALU and LSB result broadcast buses
// (wakeup), or from the buses during the dispatch cycle itself (bypass). At most
// one ready op issues per cycle, the lowest-index ready entry, into a set of
// registered outputs that feed the combinational execute unit.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rdy_in                  global ready; 0 stalls dispatch and issue
//   clear_in                synchronous mispredict flush
//   disp_*                  dispatch request and decoded op fields
//   full_out                every entry busy (combinational)
//   alu_cdb_*, lsb_cdb_*    result broadcast buses (valid, tag, data)
//   op_type_ex ...          registered issue outputs; op_type_ex = 0 means NOP
//   tag_in_rob              destination ROB tag of the issued op
// -----------------------------------------------------------------------------
module rs_alu #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  // dispatch
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic              disp_rdyj,
  input  logic              disp_rdyk,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic [DATA_W-1:0] disp_imm,
  input  logic [DATA_W-1:0] disp_pc,
  input  logic [TAG_W-1:0]  disp_tag,
  output logic              full_out,
  // result broadcast buses
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_tag,
  input  logic [DATA_W-1:0] lsb_cdb_data,
  // issue to execute
  output logic [OP_W-1:0]   op_type_ex,
  output logic [DATA_W-1:0] data_rs1_ex,
  output logic [DATA_W-1:0] data_rs2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [TAG_W-1:0]  tag_in_rob
);

  localparam logic [OP_W-1:0] OP_NOP = '0;

  // Result of looking a producer tag up on both broadcast buses.
  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  rdyj_q, rdyj_d;
  logic [DEPTH-1:0]  rdyk_q, rdyk_d;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [DATA_W-1:0] vj_q   [DEPTH];
  logic [DATA_W-1:0] vj_d   [DEPTH];
  logic [DATA_W-1:0] vk_q   [DEPTH];
  logic [DATA_W-1:0] vk_d   [DEPTH];
  logic [TAG_W-1:0]  qj_q   [DEPTH];
  logic [TAG_W-1:0]  qj_d   [DEPTH];
  logic [TAG_W-1:0]  qk_q   [DEPTH];
  logic [TAG_W-1:0]  qk_d   [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [DATA_W-1:0] imm_d  [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] pc_d   [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];

  // Issue output registers
  logic [OP_W-1:0]   op_ex_q,  op_ex_d;
  logic [DATA_W-1:0] rs1_ex_q, rs1_ex_d;
  logic [DATA_W-1:0] rs2_ex_q, rs2_ex_d;
  logic [DATA_W-1:0] imm_ex_q, imm_ex_d;
  logic [DATA_W-1:0] pc_ex_q,  pc_ex_d;
  logic [TAG_W-1:0]  tag_ex_q, tag_ex_d;

  // Selection and control
  logic [DEPTH-1:0]  ready_vec;
  logic              issue_valid;
  logic [IDX_W-1:0]  issue_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              run;
  logic              issue_fire;
  logic              disp_fire;

  // ALU bus wins when both buses carry the same tag; that case cannot occur
  // with a legal ROB, the ordering just keeps the result deterministic.
  function automatic snoop_t snoop(input logic [TAG_W-1:0] q);
    snoop_t s;
    s.hit  = 1'b0;
    s.data = '0;
    if (alu_cdb_valid && alu_cdb_tag == q) begin
      s.hit  = 1'b1;
      s.data = alu_cdb_data;
    end else if (lsb_cdb_valid && lsb_cdb_tag == q) begin
      s.hit  = 1'b1;
      s.data = lsb_cdb_data;
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Selection: readiness is taken from registered state only, so an operand
  // captured this cycle makes its entry eligible on the next edge.
  // ---------------------------------------------------------------------------
  assign ready_vec   = busy_q & rdyj_q & rdyk_q;
  assign issue_valid = |ready_vec;
  assign full_out    = &busy_q;

  // Scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    issue_idx = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) issue_idx = IDX_W'(i);
      if (!busy_q[i])   free_idx  = IDX_W'(i);
    end
  end

  // Flush beats stall, stall beats normal operation.
  assign run        = rdy_in & ~clear_in;
  assign issue_fire = run & issue_valid;
  // full_out reflects registered occupancy; a slot freed by this cycle's issue
  // is not offered to dispatch until the next cycle.
  assign disp_fire  = run & disp_valid & ~full_out;

  // ---------------------------------------------------------------------------
  // Entry next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    snoop_t sj;
    snoop_t sk;
    // NOTE: every variable driven in a combinational block gets a default
    // before any conditional code, so no path leaves it unassigned (no latch).
    sj     = '0;
    sk     = '0;
    busy_d = busy_q;
    rdyj_d = rdyj_q;
    rdyk_d = rdyk_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    tag_d  = tag_q;

    // Wakeup runs even while stalled so a broadcast is never lost.
    for (int i = 0; i < DEPTH; i++) begin
      sj = snoop(qj_q[i]);
      sk = snoop(qk_q[i]);
      if (busy_q[i] && !rdyj_q[i] && sj.hit) begin
        vj_d[i]   = sj.data;
        rdyj_d[i] = 1'b1;
      end
      if (busy_q[i] && !rdyk_q[i] && sk.hit) begin
        vk_d[i]   = sk.data;
        rdyk_d[i] = 1'b1;
      end
    end

    if (clear_in) begin
      busy_d = '0;
    end else begin
      if (issue_fire) busy_d[issue_idx] = 1'b0;
      if (disp_fire) begin
        // The dispatch slot was free at cycle start, so it never collides
        // with the issuing entry or with a wakeup above.
        sj                = snoop(disp_qj);
        sk                = snoop(disp_qk);
        busy_d[free_idx]  = 1'b1;
        op_d[free_idx]    = disp_op;
        qj_d[free_idx]    = disp_qj;
        qk_d[free_idx]    = disp_qk;
        imm_d[free_idx]   = disp_imm;
        pc_d[free_idx]    = disp_pc;
        tag_d[free_idx]   = disp_tag;
        vj_d[free_idx]    = disp_vj;
        rdyj_d[free_idx]  = disp_rdyj;
        vk_d[free_idx]    = disp_vk;
        rdyk_d[free_idx]  = disp_rdyk;
        // Bypass: the producer is broadcasting in the very cycle we dispatch.
        if (!disp_rdyj && sj.hit) begin
          vj_d[free_idx]   = sj.data;
          rdyj_d[free_idx] = 1'b1;
        end
        if (!disp_rdyk && sk.hit) begin
          vk_d[free_idx]   = sk.data;
          rdyk_d[free_idx] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue output next-state: NOP unless an entry issues; data fields hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_ex_d  = OP_NOP;
    rs1_ex_d = rs1_ex_q;
    rs2_ex_d = rs2_ex_q;
    imm_ex_d = imm_ex_q;
    pc_ex_d  = pc_ex_q;
    tag_ex_d = tag_ex_q;
    if (issue_fire) begin
      op_ex_d  = op_q[issue_idx];
      rs1_ex_d = vj_q[issue_idx];
      rs2_ex_d = vk_q[issue_idx];
      imm_ex_d = imm_q[issue_idx];
      pc_ex_d  = pc_q[issue_idx];
      tag_ex_d = tag_q[issue_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q   <= '0;
      op_ex_q  <= OP_NOP;
      rs1_ex_q <= '0;
      rs2_ex_q <= '0;
      imm_ex_q <= '0;
      pc_ex_q  <= '0;
      tag_ex_q <= '0;
    end else begin
      busy_q   <= busy_d;
      op_ex_q  <= op_ex_d;
      rs1_ex_q <= rs1_ex_d;
      rs2_ex_q <= rs2_ex_d;
      imm_ex_q <= imm_ex_d;
      pc_ex_q  <= pc_ex_d;
      tag_ex_q <= tag_ex_d;
    end
  end

  // NOTE: entry payload is only ever read through a busy bit, so the storage
  // array carries no reset; clearing busy is enough to empty the station.
  always_ff @(posedge clk_in) begin
    rdyj_q <= rdyj_d;
    rdyk_q <= rdyk_d;
    op_q   <= op_d;
    vj_q   <= vj_d;
    vk_q   <= vk_d;
    qj_q   <= qj_d;
    qk_q   <= qk_d;
    imm_q  <= imm_d;
    pc_q   <= pc_d;
    tag_q  <= tag_d;
  end

  assign op_type_ex  = op_ex_q;
  assign data_rs1_ex = rs1_ex_q;
  assign data_rs2_ex = rs2_ex_q;
  assign imm_ex      = imm_ex_q;
  assign pc_ex       = pc_ex_q;
  assign tag_in_rob  = tag_ex_q;

endmodule
